// File: rtl/dmem_if.sv
// Load/store request and response bus between the core port and the data-memory responder.
interface dmem_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) ();
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              ready;
  logic              busy;
  logic              err;

  modport master (
    output wr, rd, addr, funct3, wr_data,
    input  rd_data, ready, busy, err
  );

  modport slave (
    input  wr, rd, addr, funct3, wr_data,
    output rd_data, ready, busy, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: latches one load/store, waits WAIT_STATES cycles,
// then commits the store or returns the extended load with a one-cycle ready.
module dmem_responder #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_STATES = 2
) (
  input logic   clk,
  input logic   reset,
  dmem_if.slave bus
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned WORDS = 2 ** IDX_W;
  localparam int unsigned CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              accept;

  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_f3;
  logic [DATA_W-1:0] req_data;

  logic              cur_wr;
  logic [ADDR_W-1:0] cur_addr;
  logic [2:0]        cur_f3;
  logic [DATA_W-1:0] cur_data;
  logic [IDX_W-1:0]  cur_idx;
  logic [1:0]        cur_lane;

  logic [DATA_W-1:0] mem [WORDS];
  logic [DATA_W-1:0] cur_word;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] store_word;
  logic              legal;
  logic              enter_resp;
  logic              commit;

  logic              ready_q;
  logic              busy_q;
  logic              err_q;
  logic [DATA_W-1:0] rd_data_q;

  // State and wait counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic; requests are only seen in IDLE
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.wr || bus.rd) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_next = RESP;
        else           cnt_next   = cnt - CNT_W'(1);
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch; wr dominates rd so a dual request is a store
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_wr   <= 1'b0;
      req_addr <= '0;
      req_f3   <= '0;
      req_data <= '0;
    end else if (accept) begin
      req_wr   <= bus.wr;
      req_addr <= bus.addr;
      req_f3   <= bus.funct3;
      req_data <= bus.wr_data;
    end
  end

  // Zero wait states enter RESP on the accept edge, so use the live bus in IDLE
  always_comb begin
    cur_wr   = (state == IDLE) ? bus.wr      : req_wr;
    cur_addr = (state == IDLE) ? bus.addr    : req_addr;
    cur_f3   = (state == IDLE) ? bus.funct3 : req_f3;
    cur_data = (state == IDLE) ? bus.wr_data : req_data;
    cur_idx  = cur_addr[ADDR_W-1:2];
    cur_lane = cur_addr[1:0];
    cur_word = mem[cur_idx];
  end

  // Legality: supported funct3, natural alignment, no unsigned store variants
  always_comb begin
    legal = 1'b0;
    case (cur_f3)
      3'b000, 3'b100: legal = 1'b1;
      3'b001, 3'b101: legal = ~cur_addr[0];
      3'b010:         legal = (cur_lane == 2'b00);
      default:        legal = 1'b0;
    endcase
    if (cur_wr && cur_f3[2]) legal = 1'b0;
  end

  // Load lane select and sign/zero extension (little-endian)
  always_comb begin
    byte_v = cur_word[{cur_lane, 3'b000} +: 8];
    half_v = cur_lane[1] ? cur_word[31:16] : cur_word[15:0];
    case (cur_f3[1:0])
      2'b00:   load_val = cur_f3[2] ? {{(DATA_W-8){1'b0}}, byte_v}
                                    : {{(DATA_W-8){byte_v[7]}}, byte_v};
      2'b01:   load_val = cur_f3[2] ? {{(DATA_W-16){1'b0}}, half_v}
                                    : {{(DATA_W-16){half_v[15]}}, half_v};
      default: load_val = cur_word;
    endcase
  end

  // Store merge: only the addressed lanes change
  always_comb begin
    store_word = cur_word;
    case (cur_f3[1:0])
      2'b00: store_word[{cur_lane, 3'b000} +: 8] = cur_data[7:0];
      2'b01: begin
        if (cur_lane[1]) store_word[31:16] = cur_data[15:0];
        else             store_word[15:0]  = cur_data[15:0];
      end
      default: store_word = cur_data;
    endcase
  end

  assign enter_resp = (state_next == RESP);
  assign commit     = enter_resp && cur_wr && legal;

  // Word array; reset clears every word so an aborted store leaves zeros
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[cur_idx] <= store_word;
    end
  end

  // Registered response; rd_data holds between responses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      ready_q <= enter_resp;
      busy_q  <= (state_next != IDLE);
      err_q   <= enter_resp && !legal;
      if (enter_resp) rd_data_q <= (legal && !cur_wr) ? load_val : '0;
    end
  end

  assign bus.ready   = ready_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;
  assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_STATES=2 instance and a WAIT_STATES=0 instance.
module tb_dmem_responder;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_if #(.ADDR_W(9), .DATA_W(32)) b2 ();
  dmem_if #(.ADDR_W(9), .DATA_W(32)) b0 ();

  dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .reset(reset), .bus(b2)
  );
  dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .bus(b0)
  );

  typedef struct {
    bit          sel;
    logic        wr;
    logic        rd;
    logic [8:0]  addr;
    logic [2:0]  f3;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit s, input logic w, input logic r, input logic [8:0] a,
                              input logic [2:0] f, input logic [31:0] d,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.sel = s; v.wr = w; v.rd = r; v.addr = a; v.f3 = f; v.data = d;
    v.exp_rd = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic drive(input bit s, input logic w, input logic r, input logic [8:0] a,
                       input logic [2:0] f, input logic [31:0] d);
    if (s) begin
      b0.wr = w; b0.rd = r; b0.addr = a; b0.funct3 = f; b0.wr_data = d;
    end else begin
      b2.wr = w; b2.rd = r; b2.addr = a; b2.funct3 = f; b2.wr_data = d;
    end
  endtask

  function automatic logic get_ready(input bit s);
    return s ? b0.ready : b2.ready;
  endfunction

  function automatic logic get_busy(input bit s);
    return s ? b0.busy : b2.busy;
  endfunction

  // One request: present in IDLE, measure edges to ready, then step past RESP
  task automatic txn(input bit s, input logic w, input logic r, input logic [8:0] a,
                     input logic [2:0] f, input logic [31:0] d,
                     output logic [31:0] rdat, output logic e, output int lat,
                     output int bcnt, output logic [1:0] post);
    @(negedge clk);
    drive(s, w, r, a, f, d);
    @(posedge clk); #1;
    drive(s, 1'b0, 1'b0, 9'h000, 3'b000, 32'h0);
    lat = 0; bcnt = 0;
    while (!get_ready(s) && lat < 20) begin
      if (get_busy(s)) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (get_busy(s)) bcnt++;
    rdat = s ? b0.rd_data : b2.rd_data;
    e    = s ? b0.err : b2.err;
    @(posedge clk); #1;
    post = {get_ready(s), get_busy(s)};
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] rdat;
    logic        e;
    int          lat, bcnt, exp_lat;
    logic [1:0]  post;
    string       tag;
    exp_lat = v.sel ? 0 : 2;
    tag = $sformatf("vec%0d", idx);
    txn(v.sel, v.wr, v.rd, v.addr, v.f3, v.data, rdat, e, lat, bcnt, post);
    check({tag, " rd_data"}, rdat, v.exp_rd);
    check({tag, " err"}, 32'(e), 32'(v.exp_err));
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy_cycles"}, 32'(bcnt), 32'(exp_lat + 1));
    check({tag, " ready_busy_after"}, 32'(post), 32'h0);
  endtask

  initial begin
    logic [31:0] rdat;
    logic        e;
    int          lat, bcnt, nready;
    logic [1:0]  post;
    logic [31:0] seen;

    drive(1'b0, 1'b0, 1'b0, 9'h000, 3'b000, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 9'h000, 3'b000, 32'h0);

    // WAIT_STATES=2 instance
    vq.push_back(mk(0, 0, 1, 9'h010, F_W,  32'h0,        32'h00000000, 0));
    vq.push_back(mk(0, 1, 0, 9'h020, F_W,  32'h8899AABB, 32'h00000000, 0));
    vq.push_back(mk(0, 0, 1, 9'h023, F_B,  32'h0,        32'hFFFFFF88, 0));
    vq.push_back(mk(0, 0, 1, 9'h023, F_BU, 32'h0,        32'h00000088, 0));
    vq.push_back(mk(0, 0, 1, 9'h020, F_H,  32'h0,        32'hFFFFAABB, 0));
    vq.push_back(mk(0, 1, 0, 9'h040, F_W,  32'h11223344, 32'h00000000, 0));
    vq.push_back(mk(0, 1, 0, 9'h041, F_B,  32'hABCDEFEE, 32'h00000000, 0));
    vq.push_back(mk(0, 1, 0, 9'h042, F_H,  32'h77775566, 32'h00000000, 0));
    vq.push_back(mk(0, 0, 1, 9'h040, F_W,  32'h0,        32'h5566EE44, 0));
    vq.push_back(mk(0, 1, 0, 9'h044, F_W,  32'hCAFEF00D, 32'h00000000, 0));
    vq.push_back(mk(0, 1, 0, 9'h046, F_W,  32'h12345678, 32'h00000000, 1));
    vq.push_back(mk(0, 0, 1, 9'h043, F_H,  32'h0,        32'h00000000, 1));
    vq.push_back(mk(0, 0, 1, 9'h044, F_W,  32'h0,        32'hCAFEF00D, 0));
    vq.push_back(mk(0, 0, 1, 9'h046, F_HU, 32'h0,        32'h0000CAFE, 0));
    vq.push_back(mk(0, 0, 1, 9'h046, F_H,  32'h0,        32'hFFFFCAFE, 0));
    vq.push_back(mk(0, 0, 1, 9'h045, F_BU, 32'h0,        32'h000000F0, 0));
    vq.push_back(mk(0, 0, 1, 9'h045, F_B,  32'h0,        32'hFFFFFFF0, 0));
    vq.push_back(mk(0, 0, 1, 9'h044, 3'b011, 32'h0,      32'h00000000, 1));
    vq.push_back(mk(0, 1, 0, 9'h044, F_BU, 32'h00000000, 32'h00000000, 1));
    vq.push_back(mk(0, 0, 1, 9'h044, F_W,  32'h0,        32'hCAFEF00D, 0));
    vq.push_back(mk(0, 1, 1, 9'h060, F_W,  32'h0BADF00D, 32'h00000000, 0));
    vq.push_back(mk(0, 0, 1, 9'h060, F_W,  32'h0,        32'h0BADF00D, 0));
    vq.push_back(mk(0, 0, 1, 9'h041, F_HU, 32'h0,        32'h00000000, 1));
    // WAIT_STATES=0 instance
    vq.push_back(mk(1, 1, 0, 9'h080, F_W,  32'h600DCAFE, 32'h00000000, 0));
    vq.push_back(mk(1, 0, 1, 9'h080, F_W,  32'h0,        32'h600DCAFE, 0));
    vq.push_back(mk(1, 0, 1, 9'h081, F_H,  32'h0,        32'h00000000, 1));
    vq.push_back(mk(1, 0, 1, 9'h083, F_B,  32'h0,        32'h00000060, 0));
    vq.push_back(mk(1, 1, 0, 9'h084, 3'b110, 32'h1,      32'h00000000, 1));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset ws2 outputs", {b2.rd_data[28:0], b2.ready, b2.busy, b2.err}, 32'h0);
    check("reset ws2 rd_data", b2.rd_data, 32'h0);
    check("reset ws0 outputs", {b0.rd_data[28:0], b0.ready, b0.busy, b0.err}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vq[i]) run_vec(i, vq[i]);

    // Request pulsed while busy is dropped; only the first load completes
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 9'h020, F_W, 32'h0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 9'h000, 3'b000, 32'h0);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 9'h040, F_W, 32'h0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 9'h000, 3'b000, 32'h0);
    nready = 0; seen = 32'h0;
    repeat (8) begin
      if (b2.ready) begin
        nready++;
        seen = b2.rd_data;
      end
      @(posedge clk); #1;
    end
    check("busy drop ready count", 32'(nready), 32'd1);
    check("busy drop rd_data", seen, 32'h8899AABB);

    // Reset during WAIT aborts the store and clears outputs at once
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 9'h080, F_W, 32'hDEADBEEF);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 9'h000, 3'b000, 32'h0);
    check("busy in wait", 32'(b2.busy), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("async reset outputs", {29'h0, b2.ready, b2.busy, b2.err}, 32'h0);
    check("async reset rd_data", b2.rd_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    txn(0, 1'b0, 1'b1, 9'h080, F_W, 32'h0, rdat, e, lat, bcnt, post);
    check("aborted store word", rdat, 32'h0);
    check("aborted store latency", 32'(lat), 32'd2);
    txn(0, 1'b0, 1'b1, 9'h020, F_W, 32'h0, rdat, e, lat, bcnt, post);
    check("reset cleared word", rdat, 32'h0);
    txn(1, 1'b0, 1'b1, 9'h080, F_W, 32'h0, rdat, e, lat, bcnt, post);
    check("ws0 reset cleared word", rdat, 32'h0);
    check("ws0 latency", 32'(lat), 32'd0);
    txn(1, 1'b1, 1'b0, 9'h080, F_W, 32'hDEADBEEF, rdat, e, lat, bcnt, post);
    txn(1, 1'b0, 1'b1, 9'h082, F_HU, 32'h0, rdat, e, lat, bcnt, post);
    check("ws0 store then LHU", rdat, 32'h0000DEAD);
    check("ws0 LHU latency", 32'(lat), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder serving the core's load/store port: wr, rd, 9-bit byte address, 32-bit write data and funct3. It latches each request and inserts a parameterised number of wait states. It then commits stores with byte/halfword/word lanes and returns loads with sign or zero extension, signalling completion with a one-cycle ready pulse. It sits outside the core, on the same bus the core exports for observation.

Parameters:
DATA_W, 32, data width; fixed at 32, other values unsupported.
ADDR_W, 9, byte-address width; array is 2^(ADDR_W-2) = 128 words.
WAIT_STATES, 2, cycles spent in WAIT before RESP; 0 allowed.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
wr  input  1  store request.
rd  input  1  load request.
addr  input  ADDR_W  byte address.
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
wr_data  input  DATA_W  store data; low bits used for B/H.
rd_data  output  DATA_W  extended load result.
ready  output  1  one-cycle completion pulse.
busy  output  1  high while a request is in flight (WAIT or RESP).
err  output  1  misaligned or illegal funct3; valid with ready.

Behaviour:
- Reset (async, immediate): state=IDLE, wait counter=0, rd_data=0, ready=0, busy=0, err=0, all 128 words cleared to 0. Reset mid-request aborts it; no store commits.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on a clk edge with wr|rd=1, latch wr, rd, addr, funct3 and wr_data.
  - If WAIT_STATES=0, go to RESP; otherwise go to WAIT with counter=WAIT_STATES-1.
  - wr and rd together: treated as a store; rd ignored.
- WAIT: counter decrements each cycle; at counter=0, go to RESP on the next edge.
- Store commit: on the edge entering RESP, only when the request is legal.
- RESP (exactly 1 cycle): ready=1, busy=1, rd_data and err driven; next state IDLE.
- Requests while busy=1 are ignored and not queued. Back-to-back service needs the requester to re-present in IDLE.
- Latency: a request accepted at edge N gives ready=1 in cycle N+WAIT_STATES+1 (the cycle after edge N+WAIT_STATES).
- Word index: latched addr[ADDR_W-1:2]. Lane: addr[1:0]. Little-endian.
- Loads:
  - LB/LBU: byte at lane, sign/zero-extended.
  - LH/LHU: halfword at addr[1], sign/zero-extended.
  - LW: full word.
- Stores:
  - SB writes only byte lane addr[1:0] with wr_data[7:0].
  - SH writes the halfword with wr_data[15:0].
  - SW writes all 4 lanes.
  - Other bytes are untouched.
- Errors (err=1 in RESP, no write, rd_data=0):
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - funct3 not in {000,001,010,100,101};
  - funct3 100/101 on a store.
- ready/err/rd_data outside RESP: ready=0, err=0, rd_data holds its last value.
- A store's RESP returns rd_data=0.
- Address wrap: none needed; every ADDR_W value maps in range.

Test Plan:
- Reset then LW addr=0x010, WAIT_STATES=2 -> ready exactly 3 cycles after accept, rd_data=0x00000000, err=0, busy high for 3 cycles.
- SW 0x8899AABB @0x020, then LB @0x023 -> 0xFFFFFF88. Then LBU @0x023 -> 0x00000088. Then LH @0x020 -> 0xFFFFAABB.
- SW 0x11223344 @0x040, SB 0xEE @0x041, SH 0x5566 @0x042, then LW @0x040 -> 0x5566EE44.
- SW @0x046 and LH @0x043 -> each gives err=1 with ready; rd_data=0; a later LW @0x044 shows the word unchanged.
- Pulse rd while busy, and assert wr&rd together in IDLE -> busy-time request dropped (only one ready); dual request behaves as a store.
- Assert reset during WAIT of SW 0xDEADBEEF @0x080 -> outputs 0 immediately; subsequent LW @0x080 -> 0x00000000. Repeat with WAIT_STATES=0 -> ready on the cycle after accept.
